// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED pipeline: width derivation, position-to-data mapping and
// the decode status type.
package hamming_pkg;

  typedef enum logic [1:0] {
    Clean,
    Sec,
    Ded
  } dec_status_e;

  function automatic int calc_par_w(input int data_w);
    for (int p = 1; p < 8; p++) begin
      if ((1 << p) >= data_w + p + 1) return p;
    end
    return 8;
  endfunction

  function automatic int calc_cw_w(input int data_w);
    return data_w + calc_par_w(data_w) + 1;
  endfunction

  // Hamming position (1-based) to data bit index; -1 marks a parity position.
  function automatic int pos_to_data_idx(input int pos);
    int n_par;
    n_par = 0;
    if ((pos & (pos - 1)) == 0) return -1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) <= pos) n_par++;
    end
    return pos - 1 - n_par;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome (XOR of set-bit positions) and overall parity of a codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int CW_W  = calc_cw_w(DATA_W)
) (
  input  logic [CW_W-1:0]  code,
  output logic [PAR_W-1:0] syn,
  output logic             ovp
);

  always_comb begin
    syn = '0;
    for (int k = 0; k < CW_W - 1; k++) begin
      if (code[k]) syn = syn ^ PAR_W'(k + 1);
    end
  end

  assign ovp = ^code;

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED decoder with valid/ready handshakes. Optional saturating SEC/DED event
// counters are built only when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int CW_W  = calc_cw_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  logic              s1_valid_q;
  logic [CW_W-1:0]   s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_ovp_q;
  logic [PAR_W-1:0]  syn;
  logic              ovp;
  logic              s2_free;
  dec_status_e       status;
  logic [CW_W-1:0]   fixed;
  logic [DATA_W-1:0] data_fix;
  logic              unused_fixed;

  hamming_syndrome #(
    .DATA_W(DATA_W)
  ) u_syndrome (
    .code(in_code),
    .syn (syn),
    .ovp (ovp)
  );

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s2_free;

  always_comb begin
    status = Clean;
    fixed  = s1_code_q;
    if (s1_ovp_q) begin
      if (s1_syn_q == '0) begin
        status = Sec;
      end else if (int'(s1_syn_q) <= CW_W - 1) begin
        status = Sec;
        for (int k = 0; k < CW_W - 1; k++) begin
          if (int'(s1_syn_q) == k + 1) fixed[k] = ~fixed[k];
        end
      end else begin
        status = Ded;
      end
    end else if (s1_syn_q != '0) begin
      status = Ded;
    end
    data_fix = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (pos_to_data_idx(p) >= 0) data_fix[pos_to_data_idx(p)] = fixed[p-1];
    end
  end

  // Parity positions and the overall bit carry no data.
  assign unused_fixed = ^fixed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_ovp_q     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= in_code;
          s1_syn_q  <= syn;
          s1_ovp_q  <= ovp;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid_q;
        if (s1_valid_q) begin
          out_data     <= data_fix;
          out_syndrome <= s1_syn_q;
          out_sec      <= (status == Sec);
          out_ded      <= (status == Ded);
        end
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] sec_cnt_q;
  logic [CNT_W-1:0] ded_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sec && sec_cnt_q != '1) sec_cnt_q <= sec_cnt_q + 1'b1;
      if (out_ded && ded_cnt_q != '1) ded_cnt_q <= ded_cnt_q + 1'b1;
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Randomised bench for hamming_secded_pipe against a behavioural SECDED model and scoreboard.
// Counter expectations follow HAMMING_ERR_CNT_EN (zero when undefined).
module tb_hamming_secded_pipe;

  localparam int DW = 16;
  localparam int PW = 5;
  localparam int CW = 22;
  localparam int CNTW = 4;
  localparam int CNT_MAX = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   in_code = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_syndrome;
  logic            out_sec;
  logic            out_ded;
  logic            cnt_clr = 1'b0;
  logic [CNTW-1:0] sec_cnt;
  logic [CNTW-1:0] ded_cnt;

  hamming_secded_pipe #(
    .DATA_W(DW),
    .CNT_W (CNTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_syndrome(out_syndrome),
    .out_sec     (out_sec),
    .out_ded     (out_ded),
    .cnt_clr     (cnt_clr),
    .sec_cnt     (sec_cnt),
    .ded_cnt     (ded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic          sec;
    logic          ded;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   sec_m = 0;
  int   ded_m = 0;
  bit   bp = 1'b0;
  bit   held_v = 1'b0;
  logic [DW-1:0] held_data;
  logic [PW-1:0] held_syn;
  logic          held_sec;
  logic          held_ded;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    logic par;
    c = '0;
    j = 0;
    for (int p = 1; p < CW; p++) begin
      if (!is_pow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < PW; i++) begin
      par = 1'b0;
      for (int p = 1; p < CW; p++) begin
        if (((p >> i) & 1) == 1) par = par ^ c[p-1];
      end
      c[(1 << i) - 1] = par;
    end
    c[CW-1] = ^c;
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CW; p++) begin
      if (!is_pow2(p)) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Overall-parity bit contributes nothing to the syndrome.
  function automatic int pos_of(input int b);
    return (b == CW - 1) ? 0 : b + 1;
  endfunction

  // nflip 0/1/2 errors at bit indices b1, b2 (b1 != b2).
  task automatic send(input logic [DW-1:0] d, input int nflip, input int b1, input int b2);
    logic [CW-1:0] c;
    exp_t e;
    bit done;
    c = encode(d);
    e.data = d;
    e.syn = '0;
    e.sec = 1'b0;
    e.ded = 1'b0;
    if (nflip >= 1) c[b1] = ~c[b1];
    if (nflip == 1) begin
      e.syn = PW'(pos_of(b1));
      e.sec = 1'b1;
    end
    if (nflip == 2) begin
      c[b2] = ~c[b2];
      e.syn = PW'(pos_of(b1) ^ pos_of(b2));
      e.ded = 1'b1;
      e.data = extract(c);
    end
    in_valid = 1'b1;
    in_code = c;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        acc_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 500 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int sec_e;
    int ded_e;
    if (!rst_n) begin
      q.delete();
      sec_m = 0;
      ded_m = 0;
      held_v = 1'b0;
    end else begin
`ifdef HAMMING_ERR_CNT_EN
      sec_e = sec_m;
      ded_e = ded_m;
`else
      sec_e = 0;
      ded_e = 0;
`endif
      chk("sec_cnt", 64'(sec_cnt), 64'(sec_e));
      chk("ded_cnt", 64'(ded_cnt), 64'(ded_e));
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(held_data));
        chk("hold_syn", 64'(out_syndrome), 64'(held_syn));
        chk("hold_flags", 64'({out_sec, out_ded}), 64'({held_sec, held_ded}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("data", 64'(out_data), 64'(e.data));
          chk("syndrome", 64'(out_syndrome), 64'(e.syn));
          chk("sec", 64'(out_sec), 64'(e.sec));
          chk("ded", 64'(out_ded), 64'(e.ded));
        end
      end
      if (cnt_clr) begin
        sec_m = 0;
        ded_m = 0;
      end else if (out_valid && out_ready) begin
        if (out_sec && sec_m < CNT_MAX) sec_m++;
        if (out_ded && ded_m < CNT_MAX) ded_m++;
      end
      held_v = out_valid && !out_ready;
      held_data = out_data;
      held_syn = out_syndrome;
      held_sec = out_sec;
      held_ded = out_ded;
    end
  end

  initial begin
    logic [DW-1:0] d;
    int b1;
    int b2;
    int nf;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({out_sec, out_ded, out_syndrome}), 64'd0);
    chk("rst_counters", 64'({sec_cnt, ded_cnt}), 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Zero word, two-cycle latency.
    send(16'h0000, 0, 0, 0);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'd0);
    drain();

    send(16'hA5C3, 1, 2, 0);
    send(16'hA5C3, 2, 0, 5);
    drain();

    // Backpressure: four words offered while the sink stalls for six cycles.
    acc_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(16'h1000 + 16'(i), i % 2, 3 * i, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_accepted", 64'(acc_cnt), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Every single-bit position across random words, with random backpressure.
    bp = 1'b1;
    for (int i = 0; i < 512; i++) send(16'($urandom), 1, i % CW, 0);
    for (int i = 0; i < 100; i++) begin
      nf = $urandom_range(0, 2);
      b1 = $urandom_range(0, CW - 1);
      b2 = (b1 + $urandom_range(1, CW - 1)) % CW;
      send(16'($urandom), nf, b1, b2);
    end
    bp = 1'b0;
    drain();

    // Saturation, then clear racing a SEC handshake.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) send(16'($urandom), 1, i % CW, 0);
    drain();
`ifdef HAMMING_ERR_CNT_EN
    chk("sec_saturated", 64'(sec_cnt), 64'd15);
`else
    chk("sec_tied_zero", 64'(sec_cnt), 64'd0);
`endif
    out_ready = 1'b0;
    send(16'h5A5A, 1, 4, 0);
    for (int t = 0; t < 10 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk("clr_word_ready", 64'(out_valid), 64'd1);
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_priority", 64'(sec_cnt), 64'd0);
    drain();

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) send(16'($urandom), 1, 7, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_counters", 64'({sec_cnt, ded_cnt}), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("midrst_no_output", 64'(out_valid), 64'd0);
    end
    d = 16'hBEEF;
    send(d, 2, 1, 9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data bits per word (range 4..64).
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL derive PAR_W as the smallest P with 2^P >= DATA_W+P+1, and CW_W = DATA_W+PAR_W+1; DATA_W=16 gives PAR_W=5, CW_W=22.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_code holds a codeword.
REQ-007 in_ready  output  1  block accepts in_code this cycle.
REQ-008 in_code  input  CW_W  codeword: bit k = Hamming position k+1 for k < CW_W-1; bit CW_W-1 = overall parity.
REQ-009 out_valid  output  1  out_* fields valid.
REQ-010 out_ready  input  1  sink accepts output.
REQ-011 out_data  output  DATA_W  corrected data.
REQ-012 out_syndrome  output  PAR_W  raw Hamming syndrome.
REQ-013 out_sec  output  1  single error corrected.
REQ-014 out_ded  output  1  uncorrectable error detected.
REQ-015 cnt_clr  input  1  synchronous clear of both counters.
REQ-016 sec_cnt, ded_cnt  output  CNT_W each  saturating counts of SEC and DED events.

Function
REQ-017 Parity bits SHALL sit at positions 1,2,4,...,2^(PAR_W-1); data bits SHALL fill the remaining positions in ascending order, LSB first.
REQ-018 Stage 1 SHALL register the syndrome S (XOR of the position indices of all set bits in bits 0..CW_W-2), the overall parity O (XOR of all CW_W bits) and the codeword.
REQ-019 Stage 2 SHALL register the corrected data and the flags; latency in_valid&&in_ready to out_valid SHALL be 2 cycles with no stall.
REQ-020 S=0, O=0: data passed unchanged; sec=0, ded=0.
REQ-021 O=1, S=0: the overall-parity bit is in error; data unchanged; sec=1.
REQ-022 O=1, 1 <= S <= CW_W-1: flip position S; sec=1.
REQ-023 O=1, S > CW_W-1: ded=1, data uncorrected.
REQ-024 S != 0, O=0: ded=1, data uncorrected; sec and ded SHALL never both be 1.
REQ-025 A transfer SHALL occur only on valid&&ready at each interface; throughput SHALL be one word per cycle while out_ready=1.
REQ-026 Stage 1 SHALL advance when stage 2 is empty or out_ready=1; in_ready = !s1_valid || stage-1 advance; words SHALL never be dropped, duplicated or reordered.
REQ-027 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-028 Counters SHALL increment on an output handshake carrying sec/ded, saturate at 2^CNT_W-1 and never wrap.
REQ-029 cnt_clr SHALL take priority over a same-cycle increment (result 0).

Reset
REQ-030 With rst_n=0 at an edge: s1/s2 valids, out_valid, out_data, out_syndrome, out_sec, out_ded, sec_cnt and ded_cnt SHALL all become 0; in_ready SHALL be 1 on the first cycle after release.
REQ-031 Reset during traffic SHALL discard in-flight words; no partial output after release.

Configuration
REQ-032 With HAMMING_ERR_CNT_EN defined, the counters and cnt_clr logic SHALL be present per REQ-028/029.
REQ-033 Without HAMMING_ERR_CNT_EN, sec_cnt/ded_cnt SHALL be tied to 0, cnt_clr SHALL be ignored and no counter flops SHALL be synthesised; ports SHALL remain.

Structure
REQ-034 Package hamming_pkg SHALL hold the PAR_W/CW_W derivation functions, the position-to-data-index mapping function and a decode-status enum (CLEAN, SEC, DED).
REQ-035 Sub-module hamming_syndrome SHALL compute S and O combinationally and be instantiated in stage 1.

Verification
REQ-036 Data 0x0000 encoded -> out_data=0x0000, syndrome=0, sec=0, ded=0, 2 cycles after accept.
REQ-037 Data 0xA5C3 encoded, flip in_code[2] (position 3) -> out_data=0xA5C3, syndrome=3, sec=1; every one of the 22 single-bit flips across 512 random words -> data correct, sec=1.
REQ-038 Flip in_code[0] and in_code[5] -> syndrome=7, ded=1, sec=0, ded_cnt +1.
REQ-039 out_ready=0 for 6 cycles while 4 words are offered -> in_ready falls after 2 accepted; all 4 delivered in order after release; held outputs stable.
REQ-040 CNT_W=4, 20 single-error words -> sec_cnt=15; cnt_clr with a simultaneous SEC handshake -> sec_cnt=0.
REQ-041 DATA_W=32 build -> PAR_W=6, CW_W=39; repeat REQ-036..038 with 32-bit vectors; rst_n=0 mid-burst -> out_valid=0 next cycle, counters 0.
